// File: rtl/qspi_flash_read_arbiter.sv
// rtl/qspi_flash_read_arbiter.sv - two-requester QSPI flash byte-read arbiter with last-byte cache and watchdog
module qspi_flash_read_arbiter #(
  parameter int ADDR_W         = 24,
  parameter bit FIXED_PRIO     = 1'b0,
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  output logic              resp0_valid,
  output logic [7:0]        resp0_data,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic              resp1_valid,
  output logic [7:0]        resp1_data,
  input  logic              flush,
  output logic              flash_read_en,
  output logic [ADDR_W-1:0] flash_addr,
  input  logic              flash_ready,
  input  logic [7:0]        flash_rdata,
  output logic              timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_LOW, S_WAIT_HIGH, S_RESPOND
  } state_t;

  localparam logic [11:0] TIMER_LAST = 12'(TIMEOUT_CYCLES - 1);

  state_t            state_q;
  logic              rr_q;
  logic              win_id_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] cache_addr_q;
  logic              cache_valid_q;
  logic [7:0]        data_q;
  logic [11:0]       timer_q;

  logic              req0_ready_q, req1_ready_q;
  logic              resp0_valid_q, resp1_valid_q;
  logic [7:0]        resp0_data_q, resp1_data_q;
  logic              flash_read_en_q;
  logic [ADDR_W-1:0] flash_addr_q;
  logic              timeout_err_q;

  logic              win_sel;
  logic              any_valid;
  logic [ADDR_W-1:0] win_addr;
  logic              hit;

  always_comb begin
    win_sel = req1_valid;
    if (req0_valid && req1_valid) begin
      win_sel = FIXED_PRIO ? 1'b0 : rr_q;
    end
  end

  assign any_valid = req0_valid | req1_valid;
  assign win_addr  = win_sel ? req1_addr : req0_addr;
  // A flush in the lookup cycle must already count as a miss.
  assign hit       = cache_valid_q & ~flush & (win_addr == cache_addr_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      rr_q            <= 1'b0;
      win_id_q        <= 1'b0;
      addr_q          <= '0;
      cache_addr_q    <= '0;
      cache_valid_q   <= 1'b0;
      data_q          <= 8'h00;
      timer_q         <= '0;
      req0_ready_q    <= 1'b0;
      req1_ready_q    <= 1'b0;
      resp0_valid_q   <= 1'b0;
      resp1_valid_q   <= 1'b0;
      resp0_data_q    <= 8'h00;
      resp1_data_q    <= 8'h00;
      flash_read_en_q <= 1'b0;
      flash_addr_q    <= '0;
      timeout_err_q   <= 1'b0;
    end else begin
      req0_ready_q    <= 1'b0;
      req1_ready_q    <= 1'b0;
      resp0_valid_q   <= 1'b0;
      resp1_valid_q   <= 1'b0;
      flash_read_en_q <= 1'b0;
      timeout_err_q   <= 1'b0;
      if (flush) cache_valid_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (any_valid && (hit || flash_ready)) begin
            req0_ready_q <= ~win_sel;
            req1_ready_q <= win_sel;
            win_id_q     <= win_sel;
            addr_q       <= win_addr;
            rr_q         <= ~win_sel;
            if (hit) begin
              // data_q still holds the cached byte; only captures and aborts write it.
              state_q <= S_RESPOND;
            end else begin
              flash_addr_q    <= win_addr;
              flash_read_en_q <= 1'b1;
              state_q         <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          timer_q <= '0;
          state_q <= S_WAIT_LOW;
        end
        S_WAIT_LOW: begin
          if (timer_q == TIMER_LAST) begin
            timeout_err_q <= 1'b1;
            data_q        <= 8'hFF;
            cache_valid_q <= 1'b0;
            state_q       <= S_RESPOND;
          end else begin
            timer_q <= timer_q + 12'd1;
            if (!flash_ready) state_q <= S_WAIT_HIGH;
          end
        end
        S_WAIT_HIGH: begin
          if (flash_ready) begin
            data_q        <= flash_rdata;
            cache_addr_q  <= addr_q;
            cache_valid_q <= ~flush;
            state_q       <= S_RESPOND;
          end else if (timer_q == TIMER_LAST) begin
            timeout_err_q <= 1'b1;
            data_q        <= 8'hFF;
            cache_valid_q <= 1'b0;
            state_q       <= S_RESPOND;
          end else begin
            timer_q <= timer_q + 12'd1;
          end
        end
        S_RESPOND: begin
          resp0_valid_q <= ~win_id_q;
          resp1_valid_q <= win_id_q;
          if (win_id_q) resp1_data_q <= data_q;
          else          resp0_data_q <= data_q;
          flash_addr_q  <= '0;
          state_q       <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req0_ready    = req0_ready_q;
  assign req1_ready    = req1_ready_q;
  assign resp0_valid   = resp0_valid_q;
  assign resp1_valid   = resp1_valid_q;
  assign resp0_data    = resp0_data_q;
  assign resp1_data    = resp1_data_q;
  assign flash_read_en = flash_read_en_q;
  assign flash_addr    = flash_addr_q;
  assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_qspi_flash_read_arbiter.sv
// tb/tb_qspi_flash_read_arbiter.sv - scoreboard bench for qspi_flash_read_arbiter
module tb_qspi_flash_read_arbiter;

  typedef struct packed {
    logic       id;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  exp_t sb_a[$];
  exp_t sb_b[$];

  // DUT A: round-robin, short watchdog
  logic        a_req0_valid = 1'b0, a_req1_valid = 1'b0;
  logic [23:0] a_req0_addr = '0, a_req1_addr = '0;
  logic        a_req0_ready, a_req1_ready, a_resp0_valid, a_resp1_valid;
  logic [7:0]  a_resp0_data, a_resp1_data;
  logic        a_flash_read_en, a_timeout_err;
  logic [23:0] a_flash_addr;
  logic        fa_ready = 1'b1;
  logic [7:0]  fa_rdata = 8'h00;
  logic        fa_flush = 1'b0;
  logic [23:0] fa_addr = '0;
  int          fa_lat = 20;
  int          fa_cnt = 0;
  bit          fa_busy = 0;
  bit          fa_stall = 0;
  bit          fa_flush_cap = 0;
  int          rd_cnt_a = 0;

  // DUT B: fixed priority
  logic        b_req0_valid = 1'b0, b_req1_valid = 1'b0;
  logic [23:0] b_req0_addr = '0, b_req1_addr = '0;
  logic        b_req0_ready, b_req1_ready, b_resp0_valid, b_resp1_valid;
  logic [7:0]  b_resp0_data, b_resp1_data;
  logic        b_flash_read_en, b_timeout_err;
  logic [23:0] b_flash_addr;
  logic        fb_ready = 1'b1;
  logic [7:0]  fb_rdata = 8'h00;
  logic        b_flush = 1'b0;
  logic [23:0] fb_addr = '0;
  int          fb_cnt = 0;
  bit          fb_busy = 0;

  qspi_flash_read_arbiter #(.ADDR_W(24), .FIXED_PRIO(1'b0), .TIMEOUT_CYCLES(20)) dut_a (
    .clk(clk), .reset(reset),
    .req0_valid(a_req0_valid), .req0_addr(a_req0_addr), .req0_ready(a_req0_ready),
    .resp0_valid(a_resp0_valid), .resp0_data(a_resp0_data),
    .req1_valid(a_req1_valid), .req1_addr(a_req1_addr), .req1_ready(a_req1_ready),
    .resp1_valid(a_resp1_valid), .resp1_data(a_resp1_data),
    .flush(fa_flush), .flash_read_en(a_flash_read_en), .flash_addr(a_flash_addr),
    .flash_ready(fa_ready), .flash_rdata(fa_rdata), .timeout_err(a_timeout_err)
  );

  qspi_flash_read_arbiter #(.ADDR_W(24), .FIXED_PRIO(1'b1), .TIMEOUT_CYCLES(64)) dut_b (
    .clk(clk), .reset(reset),
    .req0_valid(b_req0_valid), .req0_addr(b_req0_addr), .req0_ready(b_req0_ready),
    .resp0_valid(b_resp0_valid), .resp0_data(b_resp0_data),
    .req1_valid(b_req1_valid), .req1_addr(b_req1_addr), .req1_ready(b_req1_ready),
    .resp1_valid(b_resp1_valid), .resp1_data(b_resp1_data),
    .flush(b_flush), .flash_read_en(b_flash_read_en), .flash_addr(b_flash_addr),
    .flash_ready(fb_ready), .flash_rdata(fb_rdata), .timeout_err(b_timeout_err)
  );

  function automatic logic [7:0] data_of(input logic [23:0] addr);
    if (addr == 24'h100000) return 8'hA5;
    return addr[7:0] ^ 8'h3C;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Flash controller models: drop ready after read_en, raise it with data after a latency.
  always @(negedge clk) begin
    if (reset) begin
      fa_ready = 1'b1; fa_busy = 0; fa_flush = 1'b0;
    end else begin
      fa_flush = 1'b0;
      if (fa_busy) begin
        fa_cnt--;
        if (fa_cnt == 0) begin
          fa_busy = 0; fa_ready = 1'b1; fa_rdata = data_of(fa_addr);
          if (fa_flush_cap) fa_flush = 1'b1;
        end
      end else if (a_flash_read_en && !fa_stall) begin
        fa_busy = 1; fa_cnt = fa_lat; fa_ready = 1'b0; fa_addr = a_flash_addr; fa_rdata = 8'h00;
      end
      if (a_flash_read_en === 1'b1) rd_cnt_a++;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      fb_ready = 1'b1; fb_busy = 0;
    end else if (fb_busy) begin
      fb_cnt--;
      if (fb_cnt == 0) begin fb_busy = 0; fb_ready = 1'b1; fb_rdata = data_of(fb_addr); end
    end else if (b_flash_read_en) begin
      fb_busy = 1; fb_cnt = 3; fb_ready = 1'b0; fb_addr = b_flash_addr;
    end
  end

  // Monitor: every response pulse is matched against the head of its scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (a_resp0_valid || a_resp1_valid)) begin
      if (sb_a.size() == 0) check("a_unexpected_resp", {a_resp1_valid, a_resp0_valid}, 0);
      else begin
        e = sb_a.pop_front();
        check("a_resp_id", {a_resp1_valid, a_resp0_valid}, e.id ? 2 : 1);
        check("a_resp_data", e.id ? a_resp1_data : a_resp0_data, e.data);
      end
    end
    if (!reset && (b_resp0_valid || b_resp1_valid)) begin
      if (sb_b.size() == 0) check("b_unexpected_resp", {b_resp1_valid, b_resp0_valid}, 0);
      else begin
        e = sb_b.pop_front();
        check("b_resp_id", {b_resp1_valid, b_resp0_valid}, e.id ? 2 : 1);
        check("b_resp_data", e.id ? b_resp1_data : b_resp0_data, e.data);
      end
    end
  end

  task automatic push_a(input logic id, input logic [7:0] d);
    exp_t e;
    e.id = id; e.data = d;
    sb_a.push_back(e);
  endtask

  task automatic push_b(input logic id, input logic [7:0] d);
    exp_t e;
    e.id = id; e.data = d;
    sb_b.push_back(e);
  endtask

  // Returns at the negedge of the cycle in which ready is seen.
  task automatic req_a(input logic id, input logic [23:0] addr);
    int n;
    if (id) begin a_req1_valid = 1'b1; a_req1_addr = addr; end
    else    begin a_req0_valid = 1'b1; a_req0_addr = addr; end
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(id ? a_req1_ready : a_req0_ready) && n < 200);
    a_req0_valid = 1'b0; a_req1_valid = 1'b0;
    if (n >= 200) check("a_accept_timeout", id ? a_req1_ready : a_req0_ready, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_a.size() != 0 || sb_b.size() != 0) && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    if (n >= 200) check("drain_timeout", sb_a.size() + sb_b.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rc, n, g;
    logic [23:0] held;
    logic [3:0] ord;

    repeat (2) @(negedge clk);
    check("reset_outputs", {a_req0_ready, a_req1_ready, a_resp0_valid, a_resp1_valid, a_flash_read_en,
                            a_timeout_err, a_flash_addr, a_resp0_data, a_resp1_data}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 1: miss, 20-cycle flash
    rc = rd_cnt_a;
    push_a(0, 8'hA5);
    req_a(0, 24'h100000);
    held = 24'h100000; n = 0;
    while (!a_resp0_valid && n < 100) begin
      if (a_flash_addr != 24'h100000) held = a_flash_addr;
      @(negedge clk); n++;
    end
    check("t1_addr_hold", held, 24'h100000);
    drain();
    check("t1_read_en_count", rd_cnt_a - rc, 1);

    // 2: hit from the other requester
    rc = rd_cnt_a;
    push_a(1, 8'hA5);
    req_a(1, 24'h100000);
    @(negedge clk);
    check("t2_hit_latency", a_resp1_valid, 1);
    drain();
    check("t2_no_read_en", rd_cnt_a - rc, 0);

    // 3a: round-robin with both valid every cycle
    for (int i = 0; i < 4; i++) push_a(i[0], 8'hA5);
    a_req0_addr = 24'h100000; a_req1_addr = 24'h100000;
    a_req0_valid = 1'b1; a_req1_valid = 1'b1;
    g = 0; n = 0; ord = '0;
    while (g < 4 && n < 100) begin
      @(negedge clk); n++;
      if (a_req0_ready) begin ord = {ord[2:0], 1'b0}; g++; end
      else if (a_req1_ready) begin ord = {ord[2:0], 1'b1}; g++; end
    end
    a_req0_valid = 1'b0; a_req1_valid = 1'b0;
    drain();
    check("t3_rr_order", ord, 4'b0101);

    // 3b: fixed priority, req1 only once req0 drops
    for (int i = 0; i < 3; i++) push_b(0, 8'h3C);
    push_b(1, 8'h3C);
    b_req0_addr = 24'h000200; b_req1_addr = 24'h000200;
    b_req0_valid = 1'b1; b_req1_valid = 1'b1;
    g = 0; n = 0; ord = '0;
    while (g < 4 && n < 100) begin
      @(negedge clk); n++;
      if (b_req0_ready) begin ord = {ord[2:0], 1'b0}; g++; end
      if (b_req1_ready) begin ord = {ord[2:0], 1'b1}; g++; end
      if (g == 3) b_req0_valid = 1'b0;
    end
    b_req0_valid = 1'b0; b_req1_valid = 1'b0;
    drain();
    check("t3_fixed_order", ord, 4'b0001);

    // 4: stalled controller -> watchdog
    fa_stall = 1;
    push_a(0, 8'hFF);
    req_a(0, 24'h000040);
    n = 0;
    while (!a_timeout_err && n < 100) begin @(negedge clk); n++; end
    check("t4_timeout_gap", n, 21);
    @(negedge clk);
    check("t4_timeout_pulse", a_timeout_err, 0);
    drain();
    fa_stall = 0;
    rc = rd_cnt_a;
    push_a(0, 8'hA5);
    req_a(0, 24'h100000);
    drain();
    check("t4_refetch_after_abort", rd_cnt_a - rc, 1);

    // 5: flush in the capture cycle
    fa_flush_cap = 1;
    push_a(1, 8'h2C);
    req_a(1, 24'h000010);
    drain();
    fa_flush_cap = 0;
    rc = rd_cnt_a;
    push_a(1, 8'h2C);
    req_a(1, 24'h000010);
    drain();
    check("t5_refetch_after_flush", rd_cnt_a - rc, 1);
    rc = rd_cnt_a;
    push_a(0, 8'h2C);
    req_a(0, 24'h000010);
    drain();
    check("t5_cached_again", rd_cnt_a - rc, 0);

    // 6: reset while waiting on the flash
    req_a(0, 24'h000080);
    repeat (6) @(negedge clk);
    #2 reset = 1'b1;
    #1 check("t6_async_clear", {a_req0_ready, a_req1_ready, a_resp0_valid, a_resp1_valid, a_flash_read_en,
                                a_timeout_err, a_flash_addr, a_resp0_data, a_resp1_data}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (25) @(negedge clk);
    rc = rd_cnt_a;
    push_a(0, 8'hBC);
    req_a(0, 24'h000080);
    drain();
    check("t6_post_reset_read", rd_cnt_a - rc, 1);

    check("sb_empty", sb_a.size() + sb_b.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
